regfile_param: RTL and testbench

Parametrised successor to the fixed 32x4 register-file BEL. Generalised in data width, depth and read-port count. Adds per-port optional output registers, a configurable write-first bypass, and a configurable post-reset memory-clear sequencer with a Busy flag. Sits in a fabric tile as a BEL:
- Data, address and enable pins connect to the switch matrix.
- Clock is exported to the top.
- Modes come from tile configuration bits.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_rd_port.sv | 52 +++++
 rtl/regfile_param.sv | 91 +++++++++
 tb/tb_regfile_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and helpers for regfile_param
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Configuration bits above the per-port output-register bits, as offsets from NUM_RD
    localparam int CFG_BYPASS = 0;
    localparam int CFG_CLEAR  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: range check, write-first bypass, optional output register
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_busy,
    input  logic              i_bypass_en,
    input  logic              i_out_reg,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_adr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_adr,
    input  logic [WIDTH-1:0]  i_mem [DEPTH],
    output logic [WIDTH-1:0]  o_rd_data
);

    // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic             w_in_range;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] r_out;

    assign w_in_range = ({1'b0, i_rd_adr} < DEPTH_C);

    always_comb begin
        w_raw = '0;
        if (!i_busy && w_in_range) begin
            if (i_bypass_en && i_wr_en && (i_wr_adr == i_rd_adr)) begin
                w_raw = i_wr_data;
            end else begin
                w_raw = i_mem[i_rd_adr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_raw;
        end
    end

    assign o_rd_data = i_out_reg ? r_out : w_raw;

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised multi-read-port register file BEL with post-reset clear
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int DEPTH        = 32,
    parameter int ADDR_W       = clog2(DEPTH),
    parameter int NUM_RD       = 2,
    parameter int NoConfigBits = NUM_RD + 2
) (
    input  logic                     UserCLK,
    input  logic                     UserRST,
    input  logic [WIDTH-1:0]         D,
    input  logic [ADDR_W-1:0]        W_ADR,
    input  logic                     W_en,
    input  logic [NUM_RD*ADDR_W-1:0] RD_ADR,
    output logic [NUM_RD*WIDTH-1:0]  RD_D,
    output logic                     Busy,
    input  logic [NoConfigBits-1:0]  ConfigBits
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_wr_in_range;
    logic              w_cfg_bypass;
    logic              w_cfg_clear;

    assign w_cfg_bypass  = ConfigBits[NUM_RD + CFG_BYPASS];
    assign w_cfg_clear   = ConfigBits[NUM_RD + CFG_CLEAR];
    assign w_wr_in_range = ({1'b0, W_ADR} < DEPTH_C);

    always_ff @(posedge UserCLK) begin
        if (UserRST) begin
            r_state   <= w_cfg_clear ? CLEAR : IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == CLEAR) && (r_clr_cnt == LAST)) begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        Busy = (r_state == CLEAR);
    end

    // Memory has no reset: contents persist unless the clear sequencer runs
    always_ff @(posedge UserCLK) begin
        if (!UserRST) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (W_en && w_wr_in_range) begin
                r_mem[W_ADR] <= D;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .i_clk       (UserCLK),
            .i_rst       (UserRST),
            .i_busy      (Busy),
            .i_bypass_en (w_cfg_bypass),
            .i_out_reg   (ConfigBits[k]),
            .i_wr_en     (W_en),
            .i_wr_adr    (W_ADR),
            .i_wr_data   (D),
            .i_rd_adr    (RD_ADR[k*ADDR_W +: ADDR_W]),
            .i_mem       (r_mem),
            .o_rd_data   (RD_D[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param
module tb_regfile_param;

    logic       clk;
    logic       rst;
    logic [3:0] d;
    logic [4:0] w_adr;
    logic       w_en;
    logic [9:0] rd_adr;
    logic [7:0] rd_d;
    logic       busy;
    logic [3:0] cfg;

    logic       rst2;
    logic [3:0] d2;
    logic [4:0] w_adr2;
    logic       w_en2;
    logic [9:0] rd_adr2;
    logic [7:0] rd_d2;
    logic       busy2;
    logic [3:0] cfg2;

    int n_checks;
    int n_pass;
    int n;

    regfile_param dut (
        .UserCLK    (clk),
        .UserRST    (rst),
        .D          (d),
        .W_ADR      (w_adr),
        .W_en       (w_en),
        .RD_ADR     (rd_adr),
        .RD_D       (rd_d),
        .Busy       (busy),
        .ConfigBits (cfg)
    );

    regfile_param #(.DEPTH(20)) dut20 (
        .UserCLK    (clk),
        .UserRST    (rst2),
        .D          (d2),
        .W_ADR      (w_adr2),
        .W_en       (w_en2),
        .RD_ADR     (rd_adr2),
        .RD_D       (rd_d2),
        .Busy       (busy2),
        .ConfigBits (cfg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_adr = {5'(a1), 5'(a0)};
        #1;
    endtask

    task automatic wait_clear_a(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; d = '0; w_adr = '0; w_en = 1'b0; rd_adr = '0; cfg = 4'b1000;
        rst2 = 1'b1; d2 = '0; w_adr2 = '0; w_en2 = 1'b0; rd_adr2 = '0; cfg2 = 4'b1000;

        // Reset with clear on: Busy high, comb ports forced to 0
        tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rd_busy", 32'(rd_d), 32'h00);
        rst = 1'b0;
        wait_clear_a(n);
        check("clr_len_init", n, 32'd32);

        // Comb ports, no bypass: old value before edge, new value after
        cfg = 4'b0000;
        w_en = 1'b1; w_adr = 5'd5; d = 4'hA;
        set_rd(5, 5);
        check("comb_old", 32'(rd_d), 32'h00);
        tick();
        w_en = 1'b0;
        #1;
        check("comb_new", 32'(rd_d), 32'hAA);

        // Bypass: same-cycle write-first on port 0, port 1 elsewhere unaffected
        cfg = 4'b0100;
        w_en = 1'b1; w_adr = 5'd7; d = 4'h3;
        set_rd(7, 8);
        check("bypass", 32'(rd_d), 32'h03);
        tick();
        w_en = 1'b0;

        // Port 0 registered, port 1 combinational
        cfg = 4'b0001;
        w_en = 1'b1; w_adr = 5'd2; d = 4'h6;
        tick();
        w_en = 1'b0;
        set_rd(2, 2);
        check("reg_p1_now", 32'(rd_d[7:4]), 32'h6);
        check("reg_p0_prev", 32'(rd_d[3:0]), 32'h3);
        tick();
        check("reg_p0_late", 32'(rd_d[3:0]), 32'h6);
        rst = 1'b1;
        tick();
        check("reg_p0_rst", 32'(rd_d[3:0]), 32'h0);
        check("reg_p1_rst", 32'(rd_d[7:4]), 32'h6);
        check("rst_nobusy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Prefill with F, then clear with a write attempt at clear cycle 10
        cfg = 4'b0000;
        for (int a = 0; a < 32; a++) begin
            w_en = 1'b1; w_adr = 5'(a); d = 4'hF;
            tick();
        end
        w_en = 1'b0;
        set_rd(0, 31);
        check("prefill", 32'(rd_d), 32'hFF);
        cfg = 4'b1000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            if (n == 9) begin
                w_en = 1'b1; w_adr = 5'd3; d = 4'h5;
            end else begin
                w_en = 1'b0;
            end
            tick();
            n++;
        end
        w_en = 1'b0;
        check("clr_len", n, 32'd32);
        cfg = 4'b0000;
        for (int a = 0; a < 32; a += 2) begin
            set_rd(a, a + 1);
            check($sformatf("clr_zero_%0d", a), 32'(rd_d), 32'h00);
        end

        // Reset reasserted at clear cycle 20 restarts the full clear
        cfg = 4'b1000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        wait_clear_a(n);
        check("mid_clr_len", n, 32'd32);

        // DEPTH=20 instance: out-of-range write dropped, read returns 0
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        n = 0;
        while (busy2 && n < 100) begin
            tick();
            n++;
        end
        check("d20_clr_len", n, 32'd20);
        cfg2 = 4'b0000;
        w_en2 = 1'b1; w_adr2 = 5'd19; d2 = 4'h9;
        tick();
        w_adr2 = 5'd25; d2 = 4'h7;
        tick();
        w_en2 = 1'b0;
        rd_adr2 = {5'd19, 5'd25};
        #1;
        check("d20_oor_rd", 32'(rd_d2[3:0]), 32'h0);
        check("d20_last", 32'(rd_d2[7:4]), 32'h9);
        rd_adr2 = {5'd9, 5'd5};
        #1;
        check("d20_no_alias", 32'(rd_d2), 32'h00);
        cfg2 = 4'b0100;
        w_en2 = 1'b1; w_adr2 = 5'd25; d2 = 4'hC;
        rd_adr2 = {5'd19, 5'd25};
        #1;
        check("d20_oor_bypass", 32'(rd_d2), 32'h90);
        w_en2 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
